// File: rtl/photon_gate_counter.sv
// Gated photon-pulse counter with a saturating count and LSB-first byte readout for SPI.
// Optional macro GATE_TIMER_EN ends each window after GATE_CYCLES counting cycles.
module photon_gate_counter #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GATE_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start_count,
    input  logic                 i_photon_in,
    input  logic                 i_tx_next,
    output logic                 o_busy,
    output logic                 o_count_valid,
    output logic                 o_overflow,
    output logic [CNT_WIDTH-1:0] o_result,
    output logic [7:0]           o_result_byte
);

    localparam int unsigned NumBytes = CNT_WIDTH / 8;
    localparam int unsigned IdxWidth = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    if ((CNT_WIDTH % 8) != 0 || CNT_WIDTH < 8 || SYNC_STAGES < 2 || GATE_CYCLES < 1)
    begin : g_param_err
        $error("photon_gate_counter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCounting,
        StDone
    } state_e;

    state_e                 r_state;
    logic [SYNC_STAGES-1:0] r_ph_sync;
    logic                   r_ph_prev;
    logic                   r_start_q;
    logic                   r_start_qq;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_flag;
    logic [CNT_WIDTH-1:0]   r_result;
    logic                   r_overflow;
    logic                   r_count_valid;
    logic                   r_busy;
    logic [IdxWidth-1:0]    r_idx;

    logic                   w_ph_rise;
    logic                   w_st_rise;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic                   w_flag_next;
    logic                   w_timeout;
    logic                   w_gate_end;
    logic [7:0]             w_result_byte;

    assign w_ph_rise = r_ph_sync[SYNC_STAGES-1] & ~r_ph_prev;
    assign w_st_rise = r_start_q & ~r_start_qq;

    // Counter saturates; the flag marks that all-ones was reached in this window.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_ph_rise && !(&r_cnt)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
        w_flag_next = r_flag | (&w_cnt_next);
    end

`ifdef GATE_TIMER_EN
    localparam int unsigned TimerWidth = $clog2(GATE_CYCLES + 1);

    logic [TimerWidth-1:0] r_timer;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (r_state != StCounting) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_timer == TimerWidth'(GATE_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_gate_end = ~r_start_q | w_timeout;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_ph_sync     <= '0;
            r_ph_prev     <= 1'b0;
            r_start_q     <= 1'b0;
            r_start_qq    <= 1'b0;
            r_cnt         <= '0;
            r_flag        <= 1'b0;
            r_result      <= '0;
            r_overflow    <= 1'b0;
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_idx         <= '0;
        end else begin
            r_ph_sync  <= {r_ph_sync[SYNC_STAGES-2:0], i_photon_in};
            r_ph_prev  <= r_ph_sync[SYNC_STAGES-1];
            r_start_q  <= i_start_count;
            r_start_qq <= r_start_q;

            case (r_state)
                StIdle, StDone: begin
                    if (w_st_rise) begin
                        r_state       <= StCounting;
                        r_cnt         <= '0;
                        r_flag        <= 1'b0;
                        r_count_valid <= 1'b0;
                        r_busy        <= 1'b1;
                    end else if (r_state == StDone && i_tx_next) begin
                        if (r_idx == IdxWidth'(NumBytes - 1)) begin
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                StCounting: begin
                    r_cnt  <= w_cnt_next;
                    r_flag <= w_flag_next;
                    // The exit cycle's photon is part of the latched result.
                    if (w_gate_end) begin
                        r_state       <= StDone;
                        r_result      <= w_cnt_next;
                        r_overflow    <= w_flag_next;
                        r_idx         <= '0;
                        r_count_valid <= 1'b1;
                        r_busy        <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        w_result_byte = 8'h00;
        for (int b = 0; b < NumBytes; b++) begin
            if (r_idx == IdxWidth'(b)) begin
                w_result_byte = r_result[8*b +: 8];
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_count_valid = r_count_valid;
    assign o_overflow    = r_overflow;
    assign o_result      = r_result;
    assign o_result_byte = w_result_byte;

endmodule

// File: tb/tb_photon_gate_counter.sv
// Directed bench for photon_gate_counter: 32-bit and 8-bit instances share stimulus;
// a third instance with a 50-cycle gate timer is exercised when GATE_TIMER_EN is defined.
module tb_photon_gate_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        photon;
    logic        tx;

    logic        busy32, valid32, ovf32;
    logic [31:0] result32;
    logic [7:0]  byte32;
    logic        busy8, valid8, ovf8;
    logic [7:0]  result8;
    logic [7:0]  byte8;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    photon_gate_counter #(
        .CNT_WIDTH  (32),
        .SYNC_STAGES(2)
    ) dut32 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_count(start),
        .i_photon_in  (photon),
        .i_tx_next    (tx),
        .o_busy       (busy32),
        .o_count_valid(valid32),
        .o_overflow   (ovf32),
        .o_result     (result32),
        .o_result_byte(byte32)
    );

    photon_gate_counter #(
        .CNT_WIDTH  (8),
        .SYNC_STAGES(2)
    ) dut8 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_count(start),
        .i_photon_in  (photon),
        .i_tx_next    (tx),
        .o_busy       (busy8),
        .o_count_valid(valid8),
        .o_overflow   (ovf8),
        .o_result     (result8),
        .o_result_byte(byte8)
    );

`ifdef GATE_TIMER_EN
    logic        start_t;
    logic        photon_t;
    logic        tx_t;
    logic        busy_t, valid_t, ovf_t;
    logic [31:0] result_t;
    logic [7:0]  byte_t;

    photon_gate_counter #(
        .CNT_WIDTH  (32),
        .SYNC_STAGES(2),
        .GATE_CYCLES(50)
    ) dut_t (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_count(start_t),
        .i_photon_in  (photon_t),
        .i_tx_next    (tx_t),
        .o_busy       (busy_t),
        .o_count_valid(valid_t),
        .o_overflow   (ovf_t),
        .o_result     (result_t),
        .o_result_byte(byte_t)
    );
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_pulses(input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            photon = 1'b1;
            tick(hi);
            photon = 1'b0;
            tick(lo);
        end
    endtask

    task automatic tx_pulse;
        tx = 1'b1;
        tick(1);
        tx = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        photon = 1'b0;
        tx     = 1'b0;
`ifdef GATE_TIMER_EN
        start_t  = 1'b0;
        photon_t = 1'b0;
        tx_t     = 1'b0;
`endif

        // Reset with the detector toggling
        for (int c = 0; c < 2; c++) begin
            photon = ~photon;
            tick(1);
        end
        check("rst_busy",   {31'd0, busy32},  32'd0);
        check("rst_valid",  {31'd0, valid32}, 32'd0);
        check("rst_ovf",    {31'd0, ovf32},   32'd0);
        check("rst_result", result32,         32'd0);
        check("rst_byte",   {24'd0, byte32},  32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            photon = ~photon;
            tick(1);
        end
        photon = 1'b0;
        tick(2);
        check("post_rst_valid",  {31'd0, valid32}, 32'd0);
        check("post_rst_busy",   {31'd0, busy32},  32'd0);
        check("post_rst_result", result32,         32'd0);

        // Basic 200-cycle window with 17 pulses
        start = 1'b1;
        tick(4);
        check("win_busy", {31'd0, busy32}, 32'd1);
        do_pulses(17, 3, 3);
        tick(94);
        start = 1'b0;
        tick(4);
        check("win17_valid",  {31'd0, valid32}, 32'd1);
        check("win17_busy",   {31'd0, busy32},  32'd0);
        check("win17_result", result32,         32'd17);
        check("win17_ovf",    {31'd0, ovf32},   32'd0);
        check("win17_res8",   {24'd0, result8}, 32'd17);

        // 300 pulses: 0x12C on 32 bits, saturates on 8 bits
        start = 1'b1;
        tick(4);
        do_pulses(300, 1, 1);
        tick(4);
        start = 1'b0;
        tick(4);
        check("win300_result", result32,         32'h0000012C);
        check("win300_ovf32",  {31'd0, ovf32},   32'd0);
        check("win300_res8",   {24'd0, result8}, 32'h000000FF);
        check("win300_ovf8",   {31'd0, ovf8},    32'd1);

        // LSB-first readout with wrap
        check("rd_byte0", {24'd0, byte32}, 32'h2C);
        tx_pulse();
        check("rd_byte1", {24'd0, byte32}, 32'h01);
        tx_pulse();
        check("rd_byte2", {24'd0, byte32}, 32'h00);
        tx_pulse();
        check("rd_byte3", {24'd0, byte32}, 32'h00);
        tx_pulse();
        check("rd_wrap",  {24'd0, byte32}, 32'h2C);
        check("rd_byte8", {24'd0, byte8},  32'hFF);
        tx_pulse();
        check("rd_byte1b", {24'd0, byte32}, 32'h01);

        // Restart from DONE with unread result; TX_NEXT collides with st_rise
        start = 1'b1;
        tick(1);
        tx = 1'b1;
        tick(1);
        tx = 1'b0;
        check("restart_valid",  {31'd0, valid32}, 32'd0);
        check("restart_busy",   {31'd0, busy32},  32'd1);
        check("restart_idx",    {24'd0, byte32},  32'h01);
        check("restart_valid8", {31'd0, valid8},  32'd0);
        tick(2);
        do_pulses(17, 3, 3);
        tick(4);
        start = 1'b0;
        tick(4);
        check("rewin_result", result32,         32'd17);
        check("rewin_res8",   {24'd0, result8}, 32'd17);
        check("rewin_ovf8",   {31'd0, ovf8},    32'd0);
        check("rewin_byte",   {24'd0, byte32},  32'h11);

        // Reset in the middle of a window
        start = 1'b1;
        tick(4);
        do_pulses(5, 2, 2);
        check("mid_busy", {31'd0, busy32}, 32'd1);
        rst_n = 1'b0;
        start = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("midrst_busy",   {31'd0, busy32},  32'd0);
        check("midrst_valid",  {31'd0, valid32}, 32'd0);
        check("midrst_result", result32,         32'd0);
        check("midrst_res8",   {24'd0, result8}, 32'd0);

`ifdef GATE_TIMER_EN
        // Timer ends the window after 50 counting cycles; held START never restarts
        for (int c = 0; c < 500; c++) begin
            if (c == 51) check("tmr_busy_before", {31'd0, busy_t}, 32'd1);
            if (c == 52) begin
                check("tmr_busy_after",  {31'd0, busy_t},  32'd0);
                check("tmr_valid_after", {31'd0, valid_t}, 32'd1);
                check("tmr_result",      result_t,         32'd5);
            end
            start_t  = 1'b1;
            photon_t = ((c % 10) == 5);
            tick(1);
        end
        check("tmr_hold_valid",  {31'd0, valid_t}, 32'd1);
        check("tmr_hold_busy",   {31'd0, busy_t},  32'd0);
        check("tmr_hold_result", result_t,         32'd5);
        start_t  = 1'b0;
        photon_t = 1'b0;
        tick(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
